// File: rtl/sb_incr_tester.sv
// rtl/sb_incr_tester.sv - SB incrementing-pattern loopback tester
module sb_incr_tester #(
    parameter int DW     = 256,
    parameter int MAXOUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   npkt,
    input  logic [7:0]    seed,
    output logic [DW-1:0] tx_data,
    output logic [31:0]   tx_dest,
    output logic          tx_last,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic [31:0]   rx_dest,
    input  logic          rx_last,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   sent_count,
    output logic [15:0]   recv_count,
    output logic [15:0]   err_count
);

    localparam int NB = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   npkt_q, npkt_d;
    logic [7:0]    seed_q, seed_d;
    logic [15:0]   sent_q, sent_d;
    logic [15:0]   recv_q, recv_d;
    logic [15:0]   err_q, err_d;
    logic          busy_q, done_q, pass_q;
    logic [15:0]   outstanding;
    logic          tx_fire, rx_fire;
    logic          rx_unsol, rx_bad;
    logic [DW-1:0] exp_data;

    // Transmit payload for packet sent_q and the payload expected back for packet recv_q
    always_comb begin
        tx_data  = '0;
        exp_data = '0;
        for (int i = 0; i < NB; i++) begin
            tx_data[8*i +: 8]  = seed_q + sent_q[7:0] + 8'(i);
            exp_data[8*i +: 8] = seed_q + recv_q[7:0] + 8'(i) + 8'd1;
        end
    end

    // tx_valid only depends on registered counts, so it stays asserted with stable
    // payload until the transfer bumps sent_q
    assign outstanding = sent_q - recv_q;
    assign tx_valid    = (state_q == S_RUN) && (sent_q < npkt_q) && (outstanding < 16'(MAXOUT));
    assign tx_dest     = {16'd0, sent_q};
    assign tx_last     = 1'b1;
    assign rx_ready    = (state_q == S_RUN);

    assign tx_fire  = tx_valid && tx_ready;
    assign rx_fire  = rx_valid && rx_ready;
    assign rx_unsol = (recv_q == sent_q);
    assign rx_bad   = (rx_data != exp_data) || (rx_dest != {16'd0, recv_q}) || !rx_last;

    // Next-state, counter and latch update logic
    always_comb begin
        state_d = state_q;
        npkt_d  = npkt_q;
        seed_d  = seed_q;
        sent_d  = sent_q;
        recv_d  = recv_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    npkt_d  = npkt;
                    seed_d  = seed;
                    sent_d  = '0;
                    recv_d  = '0;
                    err_d   = '0;
                    state_d = (npkt == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (tx_fire) begin
                    sent_d = sent_q + 16'd1;
                end
                if (rx_fire) begin
                    if (rx_unsol) begin
                        err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                    end else begin
                        recv_d = recv_q + 16'd1;
                        if (rx_bad) begin
                            err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                        end
                    end
                end
                if (recv_q == npkt_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            npkt_q  <= '0;
            seed_q  <= '0;
            sent_q  <= '0;
            recv_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            npkt_q  <= npkt_d;
            seed_q  <= seed_d;
            sent_q  <= sent_d;
            recv_q  <= recv_d;
            err_q   <= err_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
            pass_q  <= (state_d == S_DONE) && (err_d == 16'd0);
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign sent_count = sent_q;
    assign recv_count = recv_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_sb_incr_tester.sv
// tb/tb_sb_incr_tester.sv - self-checking bench for sb_incr_tester
module tb_sb_incr_tester;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  npkt;
    logic [7:0]   seed;
    logic [255:0] tx_data;
    logic [31:0]  tx_dest;
    logic         tx_last;
    logic         tx_valid;
    logic         tx_ready;
    logic [255:0] rx_data;
    logic [31:0]  rx_dest;
    logic         rx_last;
    logic         rx_valid;
    logic         rx_ready;
    logic         busy, done, pass;
    logic [15:0]  sent_count, recv_count, err_count;

    sb_incr_tester #(.DW(256), .MAXOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .npkt(npkt), .seed(seed),
        .tx_data(tx_data), .tx_dest(tx_dest), .tx_last(tx_last),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_dest(rx_dest), .rx_last(rx_last),
        .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .pass(pass),
        .sent_count(sent_count), .recv_count(recv_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet k payload: byte b = (seed + k + b + add) mod 256
    function automatic logic [255:0] pattern(input int s, input int k, input int add);
        logic [255:0] r;
        for (int b = 0; b < 32; b++) r[8*b +: 8] = 8'((s + k + b + add) % 256);
        return r;
    endfunction

    // Loopback responder state
    typedef struct {
        logic [255:0] d;
        logic [31:0]  dest;
    } pkt_t;

    pkt_t         rq[$];
    bit           running = 0;
    bit           rnd_mode = 0;
    bit           hold_rx = 0;
    int           run_seed = 0;
    int           tx_k = 0;
    int           cd_pkt = -1, cd_byte = 0, cdst_pkt = -1;
    bit           prev_stall = 0;
    logic [255:0] prev_data;
    logic [31:0]  prev_dest;

    // Responder: captures tx transfers, returns them +1 per byte on rx
    initial begin
        pkt_t p;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_dest  = '0;
        rx_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!running) begin
                tx_ready   = 1'b0;
                rx_valid   = 1'b0;
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("tx_hold_valid", tx_valid, 1);
                    chk("tx_hold_data", tx_data, prev_data);
                    chk("tx_hold_dest", tx_dest, prev_dest);
                end
                rx_valid = 1'b0;
                if (rq.size() > 0 && !hold_rx && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
                    rx_valid = 1'b1;
                    rx_data  = rq[0].d;
                    rx_dest  = rq[0].dest;
                    rx_last  = 1'b1;
                    if (rx_ready) void'(rq.pop_front());
                end
                tx_ready   = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                prev_dest  = tx_dest;
                if (tx_valid && tx_ready) begin
                    chk("tx_dest", tx_dest, tx_k);
                    chk("tx_data", tx_data, pattern(run_seed, tx_k, 0));
                    chk("tx_last", tx_last, 1);
                    for (int b = 0; b < 32; b++) p.d[8*b +: 8] = tx_data[8*b +: 8] + 8'd1;
                    p.dest = tx_dest;
                    if (tx_k == cd_pkt) p.d[8*cd_byte +: 8] = p.d[8*cd_byte +: 8] ^ 8'h5A;
                    if (tx_k == cdst_pkt) p.dest = p.dest ^ 32'h100;
                    rq.push_back(p);
                    tx_k++;
                end
            end
        end
    end

    task automatic start_run(input int np, input int sd, input int cdp, input int cdb,
                             input int cdsp, input bit rnd, input bit hold);
        @(negedge clk);
        run_seed = sd; tx_k = 0; cd_pkt = cdp; cd_byte = cdb; cdst_pkt = cdsp;
        rnd_mode = rnd; hold_rx = hold; rq.delete(); prev_stall = 0;
        npkt = 16'(np); seed = 8'(sd); start = 1'b1; running = 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input int np, input int exp_err, input bit exp_pass, input string tag);
        bit ok = 0;
        for (int i = 0; i < np * 40 + 100; i++) begin
            if (done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, ok, 1);
        chk({tag, "_pass"}, pass, exp_pass);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sent"}, sent_count, np);
        chk({tag, "_recv"}, recv_count, np);
        chk({tag, "_err"}, err_count, exp_err);
        chk({tag, "_txk"}, tx_k, np);
        chk({tag, "_rq_empty"}, rq.size(), 0);
        running = 0;
    endtask

    typedef struct {
        int   np;
        int   sd;
        int   cdp;
        int   cdb;
        int   cdsp;
        bit   rnd;
        int   exp_err;
        bit   exp_pass;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        tbl[0] = '{3,  8'h10, -1, 0,  -1, 0, 0, 1};
        tbl[1] = '{6,  8'h37,  2, 5,   4, 0, 2, 0};
        tbl[2] = '{20, 8'hA5, -1, 0,  -1, 1, 0, 1};
        tbl[3] = '{12, 8'h80,  7, 31, -1, 1, 1, 0};
        tbl[4] = '{9,  8'hF0,  3, 0,   3, 1, 1, 0};
        tbl[5] = '{0,  8'h22, -1, 0,  -1, 0, 0, 1};

        rst = 1'b1; start = 1'b0; npkt = '0; seed = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_counts", {sent_count, recv_count, err_count}, 0);
        rst = 1'b0;

        // npkt=0 from IDLE: DONE on the very next cycle, nothing sent
        start_run(0, 8'h55, -1, 0, -1, 0, 0);
        chk("zero_done", done, 1);
        chk("zero_pass", pass, 1);
        chk("zero_busy", busy, 0);
        chk("zero_tx_valid", tx_valid, 0);
        chk("zero_sent", sent_count, 0);
        running = 0;

        // Seed wrap: first payload bytes FF, 00
        start_run(1, 8'hFF, -1, 0, -1, 0, 0);
        chk("wrap_tx_bytes", tx_data[15:0], 16'h00FF);
        finish_run(1, 0, 1, "wrap");

        for (int v = 0; v < 6; v++)
        begin
            start_run(tbl[v].np, tbl[v].sd, tbl[v].cdp, tbl[v].cdb, tbl[v].cdsp, tbl[v].rnd, 0);
            finish_run(tbl[v].np, tbl[v].exp_err, tbl[v].exp_pass, $sformatf("vec%0d", v));
        end

        // Randomised runs scored by the reference model
        for (int r = 0; r < 6; r++) begin
            int np, sd, cdp, cdsp, cdb, ee;
            np   = $urandom_range(1, 25);
            sd   = $urandom_range(0, 255);
            cdp  = $urandom_range(0, np);
            cdsp = $urandom_range(0, np);
            cdb  = $urandom_range(0, 31);
            if (cdp == np) cdp = -1;
            if (cdsp == np) cdsp = -1;
            ee = 0;
            if (cdp >= 0) ee++;
            if (cdsp >= 0 && cdsp != cdp) ee++;
            start_run(np, sd, cdp, cdb, cdsp, 1, 0);
            finish_run(np, ee, ee == 0, $sformatf("rnd%0d", r));
        end

        // Withheld returns: sending stalls at MAXOUT, start in RUN ignored
        start_run(10, 8'h42, -1, 0, -1, 0, 1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (sent_count == 16'd4) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("hold_reach4", ok, 1);
        repeat (10) @(negedge clk);
        chk("hold_sent_stall", sent_count, 4);
        chk("hold_tx_valid", tx_valid, 0);
        npkt = 16'd1; seed = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold_start_ignored", busy, 1);
        hold_rx = 0;
        finish_run(10, 0, 1, "hold");

        // Reset mid-run with start asserted alongside it
        start_run(5, 8'h03, -1, 0, -1, 0, 1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (sent_count >= 16'd2) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_progress", ok, 1);
        running = 0;
        rst = 1'b1; start = 1'b1; npkt = 16'd7;
        @(negedge clk);
        chk("mid_tx_valid", tx_valid, 0);
        chk("mid_rx_ready", rx_ready, 0);
        chk("mid_flags", {busy, done, pass}, 0);
        chk("mid_counts", {sent_count, recv_count, err_count}, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("mid_stays_idle", {busy, done, tx_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
